// File: rtl/spi_poll_sched.sv
// Poll sequencer for the sensor SPI master. It issues periodic single-byte reads, times each one out,
// tracks consecutive misses and decodes each sign-magnitude byte into stepper controls.
module spi_poll_sched #(
    parameter int POLL_PERIOD    = 6_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_FAULTS     = 3,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       spi_ready_i,
    input  logic       spi_rx_dv_i,
    input  logic [7:0] spi_rx_byte_i,
    output logic       spi_tx_dv_o,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       rot_en_o,
    output logic       rot_dir_o,
    output logic [2:0] set_rate_o,
    output logic       fault_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, REQ, WAIT_RX, WAIT_PER} state_t;

    localparam int MW = $clog2(MAX_FAULTS + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(POLL_PERIOD - 1);
    localparam logic [MW-1:0]    MISS_MAX = MW'(MAX_FAULTS);

    state_t           state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [MW-1:0]    miss_cnt, miss_d;
    logic             good, timeout;

    logic       tx_d, bv_d, en_d, dir_d, fault_d, busy_d;
    logic [7:0] byte_d;
    logic [2:0] rate_d;

    function automatic logic [2:0] rate_of(input logic [6:0] m);
        if (m[6])             return 3'd7;
        else if (m[5])        return 3'd6;
        else if (m[4])        return 3'd5;
        else if (m[3])        return 3'd4;
        else if (m[2])        return 3'd3;
        else if (m == 7'd3)   return 3'd2;
        else if (m == 7'd2)   return 3'd1;
        else                  return 3'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_d;
            timer <= timer_d;
        end
    end

    // A byte arriving on the timeout cycle is still accepted as good.
    assign good    = (state == WAIT_RX) && spi_rx_dv_i;
    assign timeout = ((state == WAIT_RDY) || (state == WAIT_RX)) && !good && (timer >= TO_LAST);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (enable) state_d = WAIT_RDY;
            WAIT_RDY: begin
                if (timeout)          state_d = WAIT_PER;
                else if (spi_ready_i) state_d = REQ;
            end
            REQ:      state_d = WAIT_RX;
            WAIT_RX:  if (good || timeout) state_d = WAIT_PER;
            WAIT_PER: if (timer >= PER_LAST) state_d = enable ? WAIT_RDY : IDLE;
            default:  state_d = IDLE;
        endcase

        timer_d = timer;
        if ((state_d == WAIT_RDY) && (state != WAIT_RDY)) timer_d = '0;
        else if (state != IDLE)                           timer_d = timer + 1'b1;
    end

    always_comb begin
        tx_d    = (state_d == REQ);
        busy_d  = (state_d != IDLE);
        bv_d    = 1'b0;
        byte_d  = rx_byte_o;
        dir_d   = rot_dir_o;
        rate_d  = set_rate_o;
        en_d    = rot_en_o;
        fault_d = fault_o;
        miss_d  = miss_cnt;
        if (good) begin
            bv_d    = 1'b1;
            byte_d  = spi_rx_byte_i;
            dir_d   = spi_rx_byte_i[7];
            rate_d  = rate_of(spi_rx_byte_i[6:0]);
            en_d    = (spi_rx_byte_i[6:0] != 7'd0);
            fault_d = 1'b0;
            miss_d  = '0;
        end else if (timeout) begin
            if (miss_cnt < MISS_MAX) miss_d = miss_cnt + 1'b1;
            if (miss_d >= MISS_MAX) begin
                fault_d = 1'b1;
                en_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt     <= '0;
            spi_tx_dv_o  <= 1'b0;
            rx_byte_o    <= 8'h00;
            byte_valid_o <= 1'b0;
            rot_en_o     <= 1'b0;
            rot_dir_o    <= 1'b0;
            set_rate_o   <= 3'd0;
            fault_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            miss_cnt     <= miss_d;
            spi_tx_dv_o  <= tx_d;
            rx_byte_o    <= byte_d;
            byte_valid_o <= bv_d;
            rot_en_o     <= en_d;
            rot_dir_o    <= dir_d;
            set_rate_o   <= rate_d;
            fault_o      <= fault_d;
            busy_o       <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_poll_sched.sv
// Bench for spi_poll_sched: directed polls with hand-computed decodes, a byte scoreboard drained by a
// monitor, and strobe timing / fault / disable / async-reset checks.
module tb_spi_poll_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       spi_ready_i;
    logic       spi_rx_dv_i;
    logic [7:0] spi_rx_byte_i;
    logic       spi_tx_dv_o;
    logic [7:0] rx_byte_o;
    logic       byte_valid_o;
    logic       rot_en_o;
    logic       rot_dir_o;
    logic [2:0] set_rate_o;
    logic       fault_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_count = 0;
    logic [13:0] exp_q[$];

    spi_poll_sched #(
        .POLL_PERIOD(100), .TIMEOUT_CYCLES(60), .MAX_FAULTS(3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .spi_ready_i(spi_ready_i),
        .spi_rx_dv_i(spi_rx_dv_i), .spi_rx_byte_i(spi_rx_byte_i),
        .spi_tx_dv_o(spi_tx_dv_o), .rx_byte_o(rx_byte_o), .byte_valid_o(byte_valid_o),
        .rot_en_o(rot_en_o), .rot_dir_o(rot_dir_o), .set_rate_o(set_rate_o),
        .fault_o(fault_o), .busy_o(busy_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_push(input logic [7:0] b, input logic dir, input logic en, input logic [2:0] rate);
        exp_q.push_back({1'b0, rate, en, dir, b});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_tx(input int exp_cyc, output int at);
        int n;
        n = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!spi_tx_dv_o && n < 400);
        if (spi_tx_dv_o) at = cyc;
        chk("tx_strobe_cycle", 32'(at), 32'(exp_cyc));
        if (at < 0) at = exp_cyc;
    endtask

    task automatic send_rx(input int delay, input logic [7:0] b);
        repeat (delay) @(negedge clk);
        spi_rx_byte_i = b;
        spi_rx_dv_i   = 1'b1;
        @(negedge clk);
        spi_rx_dv_i   = 1'b0;
    endtask

    // byte scoreboard monitor
    initial begin
        logic [13:0] exp;
        logic        prev_bv;
        prev_bv = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_bv) chk("byte_valid_width", 32'(byte_valid_o), 32'd0);
            if (byte_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte_valid", {24'd0, rx_byte_o}, 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    chk("decoded_outputs",
                        32'({fault_o, set_rate_o, rot_en_o, rot_dir_o, rx_byte_o}), 32'(exp));
                end
            end
            prev_bv = byte_valid_o;
        end
    end

    // strobe monitor
    initial begin
        logic prev_tx;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_tx) chk("tx_strobe_width", 32'(spi_tx_dv_o), 32'd0);
            if (spi_tx_dv_o) tx_count++;
            prev_tx = spi_tx_dv_o;
        end
    end

    initial begin
        int s, t, e, n;
        rst = 1'b1; enable = 1'b0; spi_ready_i = 1'b0; spi_rx_dv_i = 1'b0; spi_rx_byte_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(spi_tx_dv_o), 0);
        chk("rst_outputs", 32'({rx_byte_o, byte_valid_o, rot_en_o, rot_dir_o, set_rate_o, fault_o, busy_o}), 0);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1; spi_ready_i = 1'b1; e = cyc;

        // poll 1: first strobe on 2nd cycle of WAIT_RDY, outputs still 0
        wait_tx(e + 2, t);
        s = t - 1;
        chk("pre_byte_outputs", 32'({rx_byte_o, rot_en_o, rot_dir_o, set_rate_o, fault_o}), 0);
        chk("busy_polling", 32'(busy_o), 1);
        exp_push(8'h45, 1'b0, 1'b1, 3'd7);
        send_rx(10, 8'h45);

        // polls 2-5: spacing and decode patterns
        s += 100; wait_tx(s + 1, t); exp_push(8'h83, 1'b1, 1'b1, 3'd2); send_rx(10, 8'h83);
        s += 100; wait_tx(s + 1, t); exp_push(8'h81, 1'b1, 1'b1, 3'd0); send_rx(20, 8'h81);
        s += 100; wait_tx(s + 1, t); exp_push(8'h80, 1'b1, 1'b0, 3'd0); send_rx(5, 8'h80);
        s += 100; wait_tx(s + 1, t); exp_push(8'h45, 1'b0, 1'b1, 3'd7); send_rx(30, 8'h45);

        // polls 6-8: three misses raise the fault at the end of timer cycle 59
        for (int i = 0; i < 2; i++) begin
            s += 100; wait_tx(s + 1, t);
            wait_until(s + 60);
            chk("fault_before_third_miss", 32'(fault_o), 0);
        end
        s += 100; wait_tx(s + 1, t);
        wait_until(s + 59);
        chk("fault_at_cycle59", 32'(fault_o), 0);
        wait_until(s + 60);
        chk("fault_set", 32'(fault_o), 1);
        chk("fault_rot_en", 32'(rot_en_o), 0);
        chk("fault_hold_byte", 32'({rx_byte_o, set_rate_o, rot_dir_o}), 32'({8'h45, 3'd7, 1'b0}));

        // poll 9: recovery; poll 10: rx_dv on the timeout cycle
        s += 100; wait_tx(s + 1, t); exp_push(8'h10, 1'b0, 1'b1, 3'd5); send_rx(10, 8'h10);
        s += 100; wait_tx(s + 1, t); exp_push(8'h05, 1'b0, 1'b1, 3'd3); send_rx(58, 8'h05);

        // poll 11: stray rx_dv in WAIT_PER is ignored
        s += 100; wait_tx(s + 1, t); exp_push(8'h22, 1'b0, 1'b1, 3'd6); send_rx(10, 8'h22);
        send_rx(60, 8'hFF);
        repeat (3) @(negedge clk);
        chk("stray_rx_ignored", 32'(rx_byte_o), 32'h22);
        spi_ready_i = 1'b0;

        // poll 12: ready low for 20 cycles
        s += 100;
        wait_until(s + 20);
        spi_ready_i = 1'b1;
        wait_tx(s + 21, t);
        spi_ready_i = 1'b0;
        exp_push(8'h08, 1'b0, 1'b1, 3'd4); send_rx(10, 8'h08);

        // poll 13: ready low 60 cycles is a miss; polls 14-15 complete the fault
        s += 100;
        wait_until(s + 60);
        spi_ready_i = 1'b1;
        s += 100; wait_tx(s + 1, t);
        wait_until(s + 60);
        chk("fault_after_two_misses", 32'(fault_o), 0);
        s += 100; wait_tx(s + 1, t);
        wait_until(s + 59);
        chk("fault_ready_miss_pre", 32'(fault_o), 0);
        wait_until(s + 60);
        chk("fault_ready_miss_set", 32'({fault_o, rot_en_o}), 32'b10);
        chk("fault_hold_byte2", 32'({rx_byte_o, set_rate_o}), 32'({8'h08, 3'd4}));

        // poll 16: disable mid-poll
        s += 100; wait_tx(s + 1, t);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        exp_push(8'h7F, 1'b0, 1'b1, 3'd7); send_rx(5, 8'h7F);
        wait_until(s + 99);
        chk("busy_end_of_period", 32'(busy_o), 1);
        wait_until(s + 100);
        chk("idle_after_disable", 32'(busy_o), 0);
        n = tx_count;
        repeat (250) @(negedge clk);
        chk("no_strobes_disabled", 32'(tx_count), 32'(n));
        chk("hold_after_disable", 32'({rx_byte_o, rot_en_o, set_rate_o}), 32'({8'h7F, 1'b1, 3'd7}));

        // async reset during REQ
        enable = 1'b1; e = cyc;
        wait_tx(e + 2, t);
        #2;
        rst = 1'b1; enable = 1'b0;
        #1;
        chk("async_rst_tx", 32'(spi_tx_dv_o), 0);
        chk("async_rst_outputs", 32'({rx_byte_o, rot_en_o, set_rate_o, fault_o, busy_o}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = tx_count;
        repeat (10) @(negedge clk);
        chk("idle_after_rst", 32'({busy_o, 1'b0}), 0);
        chk("no_strobe_after_rst", 32'(tx_count), 32'(n));
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_poll_sched.md
Name: spi_poll_sched

Overview:
- Sequencer that owns the SPI master used for sensor polling.
- Issues periodic single-byte read requests and supervises each transaction with a timeout.
- Decodes each received sign-magnitude byte into rot_dir/rot_en/set_rate for the stepper control unit.
- Replaces ad hoc delay-counter triggering with a deterministic poll schedule and fault tracking.

Parameters:
- POLL_PERIOD, 6_000_000: clk cycles from one poll start to the next.
- TIMEOUT_CYCLES, 5_000_000: clk cycles from poll start until the transaction is declared missed. Must be < POLL_PERIOD.
- MAX_FAULTS, 3: consecutive missed polls that assert fault_o.
- CNT_W, 24: poll timer width. Must satisfy 2^CNT_W > POLL_PERIOD.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- enable  input  1  1 = polling allowed
- spi_ready_i  input  1  SPI master ready for a new transaction
- spi_rx_dv_i  input  1  SPI master received byte valid (1-cycle pulse)
- spi_rx_byte_i  input  8  received byte
- spi_tx_dv_o  output  1  transaction start strobe to SPI master
- rx_byte_o  output  8  last good byte
- byte_valid_o  output  1  1-cycle pulse when rx_byte_o updates
- rot_en_o  output  1  motor enable
- rot_dir_o  output  1  motor direction
- set_rate_o  output  3  step rate code
- fault_o  output  1  sensor link fault
- busy_o  output  1  1 in any state except IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, timer=0, miss_cnt=0.
  - All outputs 0; rx_byte_o=8'h00.
  - spi_tx_dv_o drops immediately, even mid-strobe.
- States: IDLE, WAIT_RDY, REQ, WAIT_RX, WAIT_PER.
- Timer:
  - Cleared to 0 on entering WAIT_RDY.
  - Increments by 1 every cycle in WAIT_RDY/REQ/WAIT_RX/WAIT_PER.
  - Never wraps, by the parameter constraint.
- IDLE: enable=1 -> WAIT_RDY on the next edge.
- WAIT_RDY: spi_ready_i=1 -> REQ.
- REQ:
  - spi_tx_dv_o=1 for exactly this one cycle.
  - Next state WAIT_RX unconditionally.
- WAIT_RX, good byte: spi_rx_dv_i=1 ->
  - Latch spi_rx_byte_i into rx_byte_o and update the decode outputs on the same edge.
  - byte_valid_o=1 for the following cycle only.
  - miss_cnt=0, fault_o=0.
  - Next state WAIT_PER.
- Timeout (WAIT_RDY or WAIT_RX): timer reaches TIMEOUT_CYCLES-1 with no rx_dv ->
  - miss_cnt saturating +1; when miss_cnt reaches MAX_FAULTS, fault_o=1 and rot_en_o=0.
  - rx_byte_o and the other decode outputs hold.
  - Next state WAIT_PER.
- Simultaneous rx_dv and timeout in the same cycle: rx_dv wins, counts as good.
- spi_rx_dv_i outside WAIT_RX: ignored, no output change.
- WAIT_PER: timer reaches POLL_PERIOD-1 -> WAIT_RDY if enable=1, else IDLE.
- enable deassert mid-poll:
  - The current poll completes, including the timeout path.
  - Returns to IDLE at the end of WAIT_PER.
  - Decode outputs hold their last values.
- Poll start spacing: exactly POLL_PERIOD cycles when spi_ready_i is already 1 in WAIT_RDY.
- Decode (rx byte b, m = b[6:0]):
  - rot_dir_o = b[7].
  - rot_en_o = (m != 0) & ~fault.
  - set_rate_o = 7 if m>=64; 6 if m>=32; 5 if m>=16; 4 if m>=8; 3 if m>=4; 2 if m==3; 1 if m==2; 0 otherwise (m=0 or 1).
- Output timing: all outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Bench parameters for all scenarios: POLL_PERIOD=100, TIMEOUT_CYCLES=60, MAX_FAULTS=3.
- Reset values: assert rst, release, enable=1, spi_ready_i=1 -> spi_tx_dv_o single-cycle pulse on the 2nd cycle after entering WAIT_RDY; next pulse exactly 100 cycles later; all outputs 0 before the first byte.
- Good byte and decode: rx_dv with byte 8'h45 -> rx_byte_o=8'h45, rot_dir_o=0, set_rate_o=7, rot_en_o=1, one byte_valid_o pulse. Byte 8'h83 -> dir=1, rate=2, en=1. Byte 8'h81 -> rate=0, en=1. Byte 8'h80 -> en=0.
- Missed polls: no rx_dv for 3 consecutive polls -> fault_o rises at cycle 59 of the 3rd poll and rot_en_o=0 at the same time; rx_byte_o unchanged. A 4th poll with byte 8'h10 -> fault_o=0, rate=5, en=1.
- Timeout/rx_dv collision: rx_dv asserted in the same cycle the timer reaches 59 -> byte latched, miss_cnt stays 0.
- Stray rx and ready wait: rx_dv in WAIT_PER -> ignored. spi_ready_i held low 20 cycles -> spi_tx_dv_o issued the cycle after ready rises. spi_ready_i held low 60 cycles -> counted as a miss.
- Disable and reset mid-operation: enable=0 during WAIT_RX -> poll finishes, busy_o=0 at cycle 100, no further strobes. Async rst during REQ -> spi_tx_dv_o drops before the next clk edge; state IDLE.
